// File: rtl/dispatch_queue_pkg.sv
// Shared constants and opcode encoding for the dispatch stage.
package dispatch_queue_pkg;

  localparam int unsigned OPENUM_W     = 6;
  localparam int unsigned REG_POS_W    = 5;
  localparam int unsigned ROB_ID_W_DEF = 4;
  localparam int unsigned DATA_W_DEF   = 32;

  localparam logic [ROB_ID_W_DEF-1:0] ZERO_ROB  = '0;
  localparam logic [DATA_W_DEF-1:0]   ZERO_WORD = '0;

  typedef enum logic [OPENUM_W-1:0] {
    OPENUM_NOP = 6'd0,
    OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_LBU, OPENUM_LHU,
    OPENUM_SB, OPENUM_SH, OPENUM_SW,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
    OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
  } openum_e;

  // Loads and stores occupy one contiguous opcode range and go to the LSB.
  function automatic logic is_ls_op(input logic [OPENUM_W-1:0] op);
    return (op >= OPENUM_LB) && (op <= OPENUM_SW);
  endfunction

endpackage

// File: rtl/dispatch_queue_operand_forward.sv
// Resolves one source operand from regfile tag, CDB channels and ROB results.
module operand_forward #(
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned DATA_W   = 32
) (
  input  logic [ROB_ID_W-1:0]         q_reg,
  input  logic [DATA_W-1:0]           v_reg,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
  input  logic                        rob_ready,
  input  logic [DATA_W-1:0]           rob_value,
  output logic [ROB_ID_W-1:0]         q,
  output logic [DATA_W-1:0]           v
);

  logic hit;

  always_comb begin
    q   = q_reg;
    v   = v_reg;
    hit = 1'b0;
    if (q_reg != '0) begin
      // The first matching channel wins, so channel 0 (ALU) has priority.
      for (int unsigned i = 0; i < NUM_CDB; i++) begin
        if (!hit && cdb_valid[i] && (cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == q_reg)) begin
          hit = 1'b1;
          q   = '0;
          v   = cdb_result[i*DATA_W +: DATA_W];
        end
      end
      if (!hit && rob_ready) begin
        q = '0;
        v = rob_value;
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions and issues the head
// to ROB/regfile/RS/LSB with operands resolved at issue time.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_CDB  = 2,
  parameter int unsigned ROB_ID_W = ROB_ID_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        misbranch,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [OPENUM_W-1:0]         in_openum,
  input  logic [REG_POS_W-1:0]        in_rd,
  input  logic [REG_POS_W-1:0]        in_rs1,
  input  logic [REG_POS_W-1:0]        in_rs2,
  input  logic [DATA_W-1:0]           in_imm,
  input  logic [DATA_W-1:0]           in_pc,
  input  logic                        in_pred_jump,
  input  logic                        in_is_jump,
  input  logic                        in_is_store,
  input  logic                        in_has_rd,
  output logic [REG_POS_W-1:0]        rs1_to_reg,
  output logic [REG_POS_W-1:0]        rs2_to_reg,
  input  logic [DATA_W-1:0]           V1_from_reg,
  input  logic [DATA_W-1:0]           V2_from_reg,
  input  logic [ROB_ID_W-1:0]         Q1_from_reg,
  input  logic [ROB_ID_W-1:0]         Q2_from_reg,
  output logic [ROB_ID_W-1:0]         Q1_to_rob,
  output logic [ROB_ID_W-1:0]         Q2_to_rob,
  input  logic                        Q1_ready_from_rob,
  input  logic                        Q2_ready_from_rob,
  input  logic [DATA_W-1:0]           V1_result_from_rob,
  input  logic [DATA_W-1:0]           V2_result_from_rob,
  input  logic                        rob_full,
  input  logic                        rs_full,
  input  logic                        lsb_full,
  input  logic [ROB_ID_W-1:0]         rob_id_from_rob,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
  output logic                        ena_to_rob,
  output logic                        ena_to_reg,
  output logic                        ena_to_rs,
  output logic                        ena_to_lsb,
  output logic [REG_POS_W-1:0]        rd_to_rob,
  output logic [DATA_W-1:0]           pc_to_rob,
  output logic [DATA_W-1:0]           rollback_pc_to_rob,
  output logic                        is_jump_to_rob,
  output logic                        is_store_to_rob,
  output logic                        pred_jump_to_rob,
  output logic [REG_POS_W-1:0]        rd_to_reg,
  output logic [ROB_ID_W-1:0]         Q_to_reg,
  output logic [OPENUM_W-1:0]         openum_to_rs,
  output logic [DATA_W-1:0]           V1_to_rs,
  output logic [DATA_W-1:0]           V2_to_rs,
  output logic [ROB_ID_W-1:0]         Q1_to_rs,
  output logic [ROB_ID_W-1:0]         Q2_to_rs,
  output logic [DATA_W-1:0]           imm_to_rs,
  output logic [DATA_W-1:0]           pc_to_rs,
  output logic [ROB_ID_W-1:0]         rob_id_to_rs,
  output logic [OPENUM_W-1:0]         openum_to_lsb,
  output logic [DATA_W-1:0]           V1_to_lsb,
  output logic [DATA_W-1:0]           V2_to_lsb,
  output logic [ROB_ID_W-1:0]         Q1_to_lsb,
  output logic [ROB_ID_W-1:0]         Q2_to_lsb,
  output logic [DATA_W-1:0]           imm_to_lsb,
  output logic [DATA_W-1:0]           pc_to_lsb,
  output logic [ROB_ID_W-1:0]         rob_id_to_lsb
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [OPENUM_W-1:0]  openum;
    logic [REG_POS_W-1:0] rd;
    logic [REG_POS_W-1:0] rs1;
    logic [REG_POS_W-1:0] rs2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic                 pred_jump;
    logic                 is_jump;
    logic                 is_store;
    logic                 has_rd;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              head_e;
  entry_t              in_entry;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;
  logic                head_ls;
  logic                eligible;
  logic                issue;
  logic                push;
  logic [DATA_W-1:0]   head_rollback;
  logic [ROB_ID_W-1:0] q1_res, q2_res;
  logic [DATA_W-1:0]   v1_res, v2_res;

  assign in_entry = '{openum: in_openum, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                      imm: in_imm, pc: in_pc, pred_jump: in_pred_jump,
                      is_jump: in_is_jump, is_store: in_is_store, has_rd: in_has_rd};

  assign head_e     = mem[head];
  assign rs1_to_reg = head_e.rs1;
  assign rs2_to_reg = head_e.rs2;
  assign Q1_to_rob  = Q1_from_reg;
  assign Q2_to_rob  = Q2_from_reg;

  assign in_ready = (count != CNT_FULL) && !misbranch;
  assign push     = in_valid && in_ready && rdy && (in_openum != OPENUM_NOP);
  assign head_ls  = is_ls_op(head_e.openum);
  assign eligible = (count != '0) && !rob_full && (head_ls ? !lsb_full : !rs_full);
  assign issue    = eligible && rdy && !misbranch;

  // Restart PC if the prediction turns out wrong: the untaken path for a
  // predicted-taken jump, the branch target otherwise.
  assign head_rollback = (head_e.is_jump && !head_e.pred_jump) ? head_e.pc + head_e.imm
                                                               : head_e.pc + DATA_W'(4);

  operand_forward #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) fwd_rs1 (
    .q_reg(Q1_from_reg), .v_reg(V1_from_reg), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
    .rob_ready(Q1_ready_from_rob), .rob_value(V1_result_from_rob),
    .q(q1_res), .v(v1_res)
  );

  operand_forward #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) fwd_rs2 (
    .q_reg(Q2_from_reg), .v_reg(V2_from_reg), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
    .rob_ready(Q2_ready_from_rob), .rob_value(V2_result_from_rob),
    .q(q2_res), .v(v2_res)
  );

  always_ff @(posedge clk) begin
    if (!rst && push) mem[tail] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0; tail <= '0; count <= '0;
      ena_to_rob <= 1'b0; ena_to_reg <= 1'b0; ena_to_rs <= 1'b0; ena_to_lsb <= 1'b0;
      rd_to_rob <= '0; pc_to_rob <= '0; rollback_pc_to_rob <= '0;
      is_jump_to_rob <= 1'b0; is_store_to_rob <= 1'b0; pred_jump_to_rob <= 1'b0;
      rd_to_reg <= '0; Q_to_reg <= '0;
      openum_to_rs <= '0; V1_to_rs <= '0; V2_to_rs <= '0; Q1_to_rs <= '0;
      Q2_to_rs <= '0; imm_to_rs <= '0; pc_to_rs <= '0; rob_id_to_rs <= '0;
      openum_to_lsb <= '0; V1_to_lsb <= '0; V2_to_lsb <= '0; Q1_to_lsb <= '0;
      Q2_to_lsb <= '0; imm_to_lsb <= '0; pc_to_lsb <= '0; rob_id_to_lsb <= '0;
    end else if (misbranch) begin
      head <= '0; tail <= '0; count <= '0;
      ena_to_rob <= 1'b0; ena_to_reg <= 1'b0; ena_to_rs <= 1'b0; ena_to_lsb <= 1'b0;
    end else if (!rdy) begin
      ena_to_rob <= 1'b0; ena_to_reg <= 1'b0; ena_to_rs <= 1'b0; ena_to_lsb <= 1'b0;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (issue) head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(issue);

      ena_to_rob <= issue;
      ena_to_reg <= issue && head_e.has_rd && (head_e.rd != '0);
      ena_to_rs  <= issue && !head_ls;
      ena_to_lsb <= issue && head_ls;

      if (issue) begin
        rd_to_rob          <= head_e.rd;
        pc_to_rob          <= head_e.pc;
        rollback_pc_to_rob <= head_rollback;
        is_jump_to_rob     <= head_e.is_jump;
        is_store_to_rob    <= head_e.is_store;
        pred_jump_to_rob   <= head_e.pred_jump;
        rd_to_reg          <= head_e.rd;
        Q_to_reg           <= rob_id_from_rob;
        if (head_ls) begin
          openum_to_lsb <= head_e.openum; V1_to_lsb <= v1_res; V2_to_lsb <= v2_res;
          Q1_to_lsb <= q1_res; Q2_to_lsb <= q2_res; imm_to_lsb <= head_e.imm;
          pc_to_lsb <= head_e.pc; rob_id_to_lsb <= rob_id_from_rob;
          openum_to_rs <= '0; V1_to_rs <= '0; V2_to_rs <= '0; Q1_to_rs <= '0;
          Q2_to_rs <= '0; imm_to_rs <= '0; pc_to_rs <= '0; rob_id_to_rs <= '0;
        end else begin
          openum_to_rs <= head_e.openum; V1_to_rs <= v1_res; V2_to_rs <= v2_res;
          Q1_to_rs <= q1_res; Q2_to_rs <= q2_res; imm_to_rs <= head_e.imm;
          pc_to_rs <= head_e.pc; rob_id_to_rs <= rob_id_from_rob;
          openum_to_lsb <= '0; V1_to_lsb <= '0; V2_to_lsb <= '0; Q1_to_lsb <= '0;
          Q2_to_lsb <= '0; imm_to_lsb <= '0; pc_to_lsb <= '0; rob_id_to_lsb <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
// Scoreboard bench for dispatch_queue: a queue-based reference model predicts
// each issue, a monitor compares whatever the DUT strobes out.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst, rdy, misbranch, in_valid, in_ready;
  logic [5:0] in_openum;
  logic [4:0] in_rd, in_rs1, in_rs2, rs1_to_reg, rs2_to_reg;
  logic [31:0] in_imm, in_pc;
  logic in_pred_jump, in_is_jump, in_is_store, in_has_rd;
  logic [31:0] V1_from_reg, V2_from_reg, V1_result_from_rob, V2_result_from_rob;
  logic [3:0] Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob, rob_id_from_rob;
  logic Q1_ready_from_rob, Q2_ready_from_rob, rob_full, rs_full, lsb_full;
  logic [1:0] cdb_valid;
  logic [7:0] cdb_rob_id;
  logic [63:0] cdb_result;
  logic ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb;
  logic [4:0] rd_to_rob, rd_to_reg;
  logic [31:0] pc_to_rob, rollback_pc_to_rob;
  logic is_jump_to_rob, is_store_to_rob, pred_jump_to_rob;
  logic [3:0] Q_to_reg;
  logic [5:0] openum_to_rs, openum_to_lsb;
  logic [31:0] V1_to_rs, V2_to_rs, imm_to_rs, pc_to_rs, V1_to_lsb, V2_to_lsb, imm_to_lsb, pc_to_lsb;
  logic [3:0] Q1_to_rs, Q2_to_rs, rob_id_to_rs, Q1_to_lsb, Q2_to_lsb, rob_id_to_lsb;

  dispatch_queue #(.DEPTH(DEPTH), .NUM_CDB(2), .ROB_ID_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .misbranch(misbranch),
    .in_valid(in_valid), .in_ready(in_ready), .in_openum(in_openum), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .in_pred_jump(in_pred_jump), .in_is_jump(in_is_jump), .in_is_store(in_is_store),
    .in_has_rd(in_has_rd), .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
    .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
    .V1_result_from_rob(V1_result_from_rob), .V2_result_from_rob(V2_result_from_rob),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_id_from_rob(rob_id_from_rob), .cdb_valid(cdb_valid),
    .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
    .ena_to_rob(ena_to_rob), .ena_to_reg(ena_to_reg), .ena_to_rs(ena_to_rs),
    .ena_to_lsb(ena_to_lsb), .rd_to_rob(rd_to_rob), .pc_to_rob(pc_to_rob),
    .rollback_pc_to_rob(rollback_pc_to_rob), .is_jump_to_rob(is_jump_to_rob),
    .is_store_to_rob(is_store_to_rob), .pred_jump_to_rob(pred_jump_to_rob),
    .rd_to_reg(rd_to_reg), .Q_to_reg(Q_to_reg),
    .openum_to_rs(openum_to_rs), .V1_to_rs(V1_to_rs), .V2_to_rs(V2_to_rs),
    .Q1_to_rs(Q1_to_rs), .Q2_to_rs(Q2_to_rs), .imm_to_rs(imm_to_rs),
    .pc_to_rs(pc_to_rs), .rob_id_to_rs(rob_id_to_rs),
    .openum_to_lsb(openum_to_lsb), .V1_to_lsb(V1_to_lsb), .V2_to_lsb(V2_to_lsb),
    .Q1_to_lsb(Q1_to_lsb), .Q2_to_lsb(Q2_to_lsb), .imm_to_lsb(imm_to_lsb),
    .pc_to_lsb(pc_to_lsb), .rob_id_to_lsb(rob_id_to_lsb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm, pc;
    logic pj, ij, st, hrd;
  } instr_t;

  typedef struct {
    int cyc;
    bit is_rst;
    bit ls;
    bit ereg;
    instr_t ins;
    logic [3:0] rob_id, q1, q2;
    logic [31:0] v1, v2;
  } exp_t;

  instr_t mq[$];
  exp_t   sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A tag of zero means the value is already known; otherwise the first CDB
  // channel carrying the tag supplies it, then a completed ROB entry.
  function automatic void resolve(input logic [3:0] qr, input logic [31:0] vr,
                                  input logic rr, input logic [31:0] rv,
                                  output logic [3:0] q, output logic [31:0] v);
    q = qr;
    v = vr;
    if (qr == 4'd0) return;
    for (int i = 0; i < 2; i++) begin
      if (cdb_valid[i] && cdb_rob_id[i*4 +: 4] == qr) begin
        q = ZERO_ROB;
        v = cdb_result[i*32 +: 32];
        return;
      end
    end
    if (rr) begin
      q = ZERO_ROB;
      v = rv;
    end
  endfunction

  task automatic model_step();
    exp_t e;
    instr_t ins, cur;
    bit m_ready, ls;
    if (rst) begin
      mq.delete();
      e.cyc = cyc + 1;
      e.is_rst = 1'b1;
      sb.push_back(e);
      return;
    end
    m_ready = (mq.size() < DEPTH) && !misbranch;
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    chk("Q1_to_rob", 64'(Q1_to_rob), 64'(Q1_from_reg));
    if (mq.size() > 0) begin
      chk("rs1_to_reg", 64'(rs1_to_reg), 64'(mq[0].rs1));
      chk("rs2_to_reg", 64'(rs2_to_reg), 64'(mq[0].rs2));
    end
    if (misbranch) begin
      mq.delete();
      return;
    end
    if (!rdy) return;
    if (mq.size() > 0) begin
      ins = mq[0];
      ls = (ins.op >= 6'(OPENUM_LB)) && (ins.op <= 6'(OPENUM_SW));
      if (!rob_full && !(ls ? lsb_full : rs_full)) begin
        e.cyc = cyc + 1;
        e.is_rst = 1'b0;
        e.ls = ls;
        e.ins = ins;
        e.ereg = ins.hrd && (ins.rd != 5'd0);
        e.rob_id = rob_id_from_rob;
        resolve(Q1_from_reg, V1_from_reg, Q1_ready_from_rob, V1_result_from_rob, e.q1, e.v1);
        resolve(Q2_from_reg, V2_from_reg, Q2_ready_from_rob, V2_result_from_rob, e.q2, e.v2);
        sb.push_back(e);
        void'(mq.pop_front());
      end
    end
    if (in_valid && m_ready && in_openum != 6'(OPENUM_NOP)) begin
      cur = '{op: in_openum, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm, pc: in_pc,
              pj: in_pred_jump, ij: in_is_jump, st: in_is_store, hrd: in_has_rd};
      mq.push_back(cur);
    end
  endtask

  // Monitor: pops the expectation due at this edge and compares the strobes.
  initial begin
    exp_t e;
    logic [5:0]  s_op;
    logic [31:0] s_v1, s_v2, s_imm, s_pc, rb;
    logic [3:0]  s_q1, s_q2, s_id;
    logic        other_nz;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        if (e.is_rst) begin
          chk("rst_ena", 64'({ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb}), 64'd0);
          chk("rst_payload", 64'(|{rd_to_rob, pc_to_rob, rollback_pc_to_rob, is_jump_to_rob,
              is_store_to_rob, pred_jump_to_rob, rd_to_reg, Q_to_reg, openum_to_rs, V1_to_rs,
              V2_to_rs, Q1_to_rs, Q2_to_rs, imm_to_rs, pc_to_rs, rob_id_to_rs, openum_to_lsb,
              V1_to_lsb, V2_to_lsb, Q1_to_lsb, Q2_to_lsb, imm_to_lsb, pc_to_lsb, rob_id_to_lsb}), 64'd0);
        end else begin
          rb = (e.ins.ij && !e.ins.pj) ? e.ins.pc + e.ins.imm : e.ins.pc + 32'd4;
          chk("ena_to_rob", 64'(ena_to_rob), 64'd1);
          chk("ena_to_rs", 64'(ena_to_rs), 64'(!e.ls));
          chk("ena_to_lsb", 64'(ena_to_lsb), 64'(e.ls));
          chk("ena_to_reg", 64'(ena_to_reg), 64'(e.ereg));
          chk("rd_to_rob", 64'(rd_to_rob), 64'(e.ins.rd));
          chk("pc_to_rob", 64'(pc_to_rob), 64'(e.ins.pc));
          chk("rollback_pc", 64'(rollback_pc_to_rob), 64'(rb));
          chk("rob_flags", 64'({is_jump_to_rob, is_store_to_rob, pred_jump_to_rob}),
              64'({e.ins.ij, e.ins.st, e.ins.pj}));
          chk("rd_to_reg", 64'(rd_to_reg), 64'(e.ins.rd));
          chk("Q_to_reg", 64'(Q_to_reg), 64'(e.rob_id));
          if (e.ls) begin
            s_op = openum_to_lsb; s_v1 = V1_to_lsb; s_v2 = V2_to_lsb; s_q1 = Q1_to_lsb;
            s_q2 = Q2_to_lsb; s_imm = imm_to_lsb; s_pc = pc_to_lsb; s_id = rob_id_to_lsb;
            other_nz = |{openum_to_rs, V1_to_rs, V2_to_rs, Q1_to_rs, Q2_to_rs, imm_to_rs,
                         pc_to_rs, rob_id_to_rs};
          end else begin
            s_op = openum_to_rs; s_v1 = V1_to_rs; s_v2 = V2_to_rs; s_q1 = Q1_to_rs;
            s_q2 = Q2_to_rs; s_imm = imm_to_rs; s_pc = pc_to_rs; s_id = rob_id_to_rs;
            other_nz = |{openum_to_lsb, V1_to_lsb, V2_to_lsb, Q1_to_lsb, Q2_to_lsb, imm_to_lsb,
                         pc_to_lsb, rob_id_to_lsb};
          end
          chk("st_openum", 64'(s_op), 64'(e.ins.op));
          chk("st_V1", 64'(s_v1), 64'(e.v1));
          chk("st_V2", 64'(s_v2), 64'(e.v2));
          chk("st_Q1", 64'(s_q1), 64'(e.q1));
          chk("st_Q2", 64'(s_q2), 64'(e.q2));
          chk("st_imm", 64'(s_imm), 64'(e.ins.imm));
          chk("st_pc", 64'(s_pc), 64'(e.ins.pc));
          chk("st_rob_id", 64'(s_id), 64'(e.rob_id));
          chk("unused_station_zero", 64'(other_nz), 64'd0);
        end
      end else if ({ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb} != 4'd0) begin
        chk("spurious_ena", 64'({ena_to_rob, ena_to_reg, ena_to_rs, ena_to_lsb}), 64'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_env();
    V1_from_reg = '0; V2_from_reg = '0; Q1_from_reg = '0; Q2_from_reg = '0;
    Q1_ready_from_rob = 1'b0; Q2_ready_from_rob = 1'b0;
    V1_result_from_rob = '0; V2_result_from_rob = '0;
    cdb_valid = '0; cdb_rob_id = '0; cdb_result = '0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_id_from_rob = 4'd1;
  endtask

  task automatic rand_env(input int full_pct);
    V1_from_reg = $urandom; V2_from_reg = $urandom;
    Q1_from_reg = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
    Q2_from_reg = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
    Q1_ready_from_rob = 1'($urandom); Q2_ready_from_rob = 1'($urandom);
    V1_result_from_rob = $urandom; V2_result_from_rob = $urandom;
    cdb_valid = 2'($urandom);
    cdb_rob_id = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
    cdb_result = {$urandom, $urandom};
    rob_full = ($urandom_range(0, 99) < full_pct);
    rs_full  = ($urandom_range(0, 99) < full_pct);
    lsb_full = ($urandom_range(0, 99) < full_pct);
    rob_id_from_rob = 4'($urandom);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                           input logic [31:0] imm, pc, input logic pj, ij, st, hrd);
    in_valid = 1'b1; in_openum = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_pc = pc; in_pred_jump = pj; in_is_jump = ij;
    in_is_store = st; in_has_rd = hrd;
  endtask

  task automatic rand_instr();
    set_instr(6'($urandom_range(0, 37)), 5'($urandom), 5'($urandom), 5'($urandom),
              $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; misbranch = 1'b0;
    idle_env();
    set_instr(OPENUM_NOP, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // ADD x3,x1,x2 with both operands ready in the regfile
    set_instr(OPENUM_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
    V1_from_reg = 32'd5; V2_from_reg = 32'd7; rob_id_from_rob = 4'd6;
    tick();
    in_valid = 1'b0;
    tick(); tick();

    // LW: operand forwarded from CDB channel 1, then unresolved
    set_instr(OPENUM_LW, 5'd5, 5'd3, 5'd0, 32'd4, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_env(); tick();
    in_valid = 1'b0; Q1_from_reg = 4'd3; cdb_valid = 2'b10;
    cdb_rob_id = {4'd3, 4'd0}; cdb_result = {32'h100, 32'h0};
    tick();
    set_instr(OPENUM_LW, 5'd6, 5'd3, 5'd0, 32'd8, 32'h1008, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_env(); tick();
    in_valid = 1'b0; Q1_from_reg = 4'd3; cdb_valid = 2'b00; Q1_ready_from_rob = 1'b0;
    tick();

    // Both channels match: channel 0 wins; tag 0 never forwards
    set_instr(OPENUM_LW, 5'd7, 5'd3, 5'd0, 32'd12, 32'h100c, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_env(); tick();
    in_valid = 1'b0; Q1_from_reg = 4'd3; cdb_valid = 2'b11;
    cdb_rob_id = {4'd3, 4'd3}; cdb_result = {32'hB, 32'hA};
    tick();
    set_instr(OPENUM_ADD, 5'd8, 5'd1, 5'd2, 32'd0, 32'h1010, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_env(); tick();
    in_valid = 1'b0; V1_from_reg = 32'h55; cdb_valid = 2'b11;
    cdb_rob_id = '0; cdb_result = {32'hB, 32'hA};
    tick();

    // Fill with rs_full, then a push attempt while the head pops
    idle_env(); rs_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_instr(OPENUM_ADD, 5'(i + 1), 5'd1, 5'd2, 32'(i), 32'h2000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    set_instr(OPENUM_SUB, 5'd9, 5'd1, 5'd2, 32'd9, 32'h2010, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    rs_full = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Misbranch with three entries queued and a same-cycle push
    rs_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(OPENUM_XOR, 5'(i + 10), 5'd1, 5'd2, 32'(i), 32'h3000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    misbranch = 1'b1;
    set_instr(OPENUM_OR, 5'd20, 5'd1, 5'd2, 32'd0, 32'h3100, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    misbranch = 1'b0; in_valid = 1'b0; rs_full = 1'b0;
    tick();
    set_instr(OPENUM_AND, 5'd21, 5'd1, 5'd2, 32'd0, 32'h3200, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();

    // rdy low with an eligible head
    set_instr(OPENUM_SW, 5'd0, 5'd4, 5'd5, 32'd16, 32'h4000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rdy = 1'b1;
    tick(); tick();

    // Randomized traffic with a mid-stream reset
    for (int n = 0; n < 500; n++) begin
      rand_env(25);
      rst = (n == 250);
      rdy = ($urandom_range(0, 9) != 0);
      misbranch = ($urandom_range(0, 39) == 0);
      rand_instr();
      in_valid = rdy && ($urandom_range(0, 9) < 7);
      tick();
    end

    rst = 1'b0; rdy = 1'b1; misbranch = 1'b0; in_valid = 1'b0;
    idle_env();
    for (int i = 0; i < 10; i++) tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("model_queue_drained", 64'(mq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
